mem_stage_wb: RTL and testbench

MEM_STAGE_WB -- requirements
Module: mem_stage_wb

---
 rtl/mem_stage_wb.sv | 128 ++++++++++++
 tb/tb_mem_stage_wb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_wb.sv
// ---------------------------------------------------------------------------
// mem_stage_wb
// MEM stage of a 5-stage pipeline plus the MEM/WB pipeline register.
// Resolves the branch decision combinationally, performs word-aligned
// data-memory loads/stores, flags misaligned accesses (sticky), and keeps
// saturating load/store counters.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   in_branch_target    : branch target from EX
//   in_zf               : ALU zero flag
//   in_alu_result       : ALU result / data-memory byte address
//   in_store_data       : store data
//   in_write_reg        : destination register number
//   in_branch, in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg
//                       : EX/MEM control bits
//   pc_src, flush       : branch taken (combinational)
//   branch_target       : pass-through of in_branch_target
//   out_read_data, out_alu_result, out_write_reg, out_reg_write,
//   out_mem_to_reg      : MEM/WB registered fields
//   misalign_err        : sticky misaligned-access flag
//   load_count, store_count : saturating access counters
// ---------------------------------------------------------------------------
module mem_stage_wb #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_branch_target,
    input  logic             in_zf,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_store_data,
    input  logic [4:0]       in_write_reg,
    input  logic             in_branch,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    output logic             pc_src,
    output logic [31:0]      branch_target,
    output logic             flush,
    output logic [31:0]      out_read_data,
    output logic [31:0]      out_alu_result,
    output logic [4:0]       out_write_reg,
    output logic             out_reg_write,
    output logic             out_mem_to_reg,
    output logic             misalign_err,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic [31:0]      r_read_data;
    logic [31:0]      r_alu_result;
    logic [4:0]       r_write_reg;
    logic             r_reg_write;
    logic             r_mem_to_reg;
    logic             r_misalign_err;
    logic [CNT_W-1:0] r_load_count;
    logic [CNT_W-1:0] r_store_count;

    logic [AW-1:0]    w_idx;
    logic             w_aligned;
    logic             w_misalign;
    logic             w_rd_ok;
    logic             w_wr_ok;

    // Upper address bits are dropped, so addresses wrap modulo 4*DEPTH_WORDS.
    assign w_idx      = in_alu_result[AW+1:2];
    assign w_aligned  = (in_alu_result[1:0] == 2'b00);
    assign w_misalign = !w_aligned && (in_mem_read || in_mem_write);
    assign w_rd_ok    = in_mem_read  && w_aligned;
    assign w_wr_ok    = in_mem_write && w_aligned;

    assign pc_src        = in_branch && in_zf;
    assign flush         = pc_src;
    assign branch_target = in_branch_target;

    // Data array is never reset; rst only blocks a write on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[w_idx] <= in_store_data;
        end
    end

    // Read data comes straight from the array, so a simultaneous write
    // leaves the captured value as the pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data    <= '0;
            r_alu_result   <= '0;
            r_write_reg    <= '0;
            r_reg_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_misalign_err <= 1'b0;
            r_load_count   <= '0;
            r_store_count  <= '0;
        end else begin
            r_read_data  <= w_rd_ok ? r_mem[w_idx] : '0;
            r_alu_result <= in_alu_result;
            r_write_reg  <= in_write_reg;
            r_reg_write  <= in_reg_write && !w_misalign;
            r_mem_to_reg <= in_mem_to_reg;
            if (w_misalign) begin
                r_misalign_err <= 1'b1;
            end
            if (w_rd_ok && (r_load_count != '1)) begin
                r_load_count <= r_load_count + 1'b1;
            end
            if (w_wr_ok && (r_store_count != '1)) begin
                r_store_count <= r_store_count + 1'b1;
            end
        end
    end

    assign out_read_data  = r_read_data;
    assign out_alu_result = r_alu_result;
    assign out_write_reg  = r_write_reg;
    assign out_reg_write  = r_reg_write;
    assign out_mem_to_reg = r_mem_to_reg;
    assign misalign_err   = r_misalign_err;
    assign load_count     = r_load_count;
    assign store_count    = r_store_count;

endmodule

// File: tb/tb_mem_stage_wb.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_wb
// Directed scoreboard bench for mem_stage_wb (DEPTH_WORDS=64, CNT_W=3 so
// counter saturation is reachable). The driver pushes hand-computed
// MEM/WB expectations; a monitor pops one entry after each rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage_wb;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned CW    = 3;

    logic          clk;
    logic          rst;
    logic [31:0]   in_branch_target;
    logic          in_zf;
    logic [31:0]   in_alu_result;
    logic [31:0]   in_store_data;
    logic [4:0]    in_write_reg;
    logic          in_branch;
    logic          in_mem_read;
    logic          in_mem_write;
    logic          in_reg_write;
    logic          in_mem_to_reg;
    logic          pc_src;
    logic [31:0]   branch_target;
    logic          flush;
    logic [31:0]   out_read_data;
    logic [31:0]   out_alu_result;
    logic [4:0]    out_write_reg;
    logic          out_reg_write;
    logic          out_mem_to_reg;
    logic          misalign_err;
    logic [CW-1:0] load_count;
    logic [CW-1:0] store_count;

    mem_stage_wb #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_branch_target (in_branch_target),
        .in_zf            (in_zf),
        .in_alu_result    (in_alu_result),
        .in_store_data    (in_store_data),
        .in_write_reg     (in_write_reg),
        .in_branch        (in_branch),
        .in_mem_read      (in_mem_read),
        .in_mem_write     (in_mem_write),
        .in_reg_write     (in_reg_write),
        .in_mem_to_reg    (in_mem_to_reg),
        .pc_src           (pc_src),
        .branch_target    (branch_target),
        .flush            (flush),
        .out_read_data    (out_read_data),
        .out_alu_result   (out_alu_result),
        .out_write_reg    (out_write_reg),
        .out_reg_write    (out_reg_write),
        .out_mem_to_reg   (out_mem_to_reg),
        .misalign_err     (misalign_err),
        .load_count       (load_count),
        .store_count      (store_count)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        regwr;
        logic        m2r;
        logic        mis;
        logic [31:0] lc;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one MEM/WB capture per rising edge, compared against the queue head.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("read_data",  out_read_data,  e.rdata);
            chk("alu_result", out_alu_result, e.alu);
            chk("write_reg",  {27'd0, out_write_reg}, {27'd0, e.wreg});
            chk("reg_write",  {31'd0, out_reg_write}, {31'd0, e.regwr});
            chk("mem_to_reg", {31'd0, out_mem_to_reg}, {31'd0, e.m2r});
            chk("misalign",   {31'd0, misalign_err}, {31'd0, e.mis});
            chk("load_count", {29'd0, load_count}, e.lc);
            chk("store_count",{29'd0, store_count}, e.sc);
        end
    end

    task automatic nop();
        in_branch = 1'b0; in_zf = 1'b0; in_branch_target = '0;
        in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0;
        in_mem_to_reg = 1'b0; in_alu_result = '0; in_store_data = '0;
        in_write_reg = '0;
    endtask

    // Apply one access at the falling edge and queue its expected capture.
    task automatic op(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic regwr, input logic [4:0] wreg,
                      input logic [31:0] x_rdata, input logic x_regwr, input logic x_mis,
                      input int x_lc, input int x_sc);
        exp_t e;
        @(negedge clk);
        nop();
        in_mem_read = rd; in_mem_write = wr; in_alu_result = addr;
        in_store_data = wdata; in_reg_write = regwr; in_write_reg = wreg;
        in_mem_to_reg = rd;
        e.rdata = x_rdata; e.alu = addr; e.wreg = wreg; e.regwr = x_regwr;
        e.m2r = rd; e.mis = x_mis; e.lc = x_lc; e.sc = x_sc;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        nop();
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdata"}, out_read_data, 32'h0);
        chk({tag, "_alu"},   out_alu_result, 32'h0);
        chk({tag, "_wreg"},  {27'd0, out_write_reg}, 32'h0);
        chk({tag, "_flags"}, {29'd0, out_reg_write, out_mem_to_reg, misalign_err}, 32'h0);
        chk({tag, "_cnt"},   {26'd0, load_count, store_count}, 32'h0);
    endtask

    initial begin
        nop();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Branch resolution is combinational.
        in_branch = 1'b1; in_zf = 1'b1; in_branch_target = 32'h40;
        #1;
        chk("pc_src_taken", {31'd0, pc_src}, 32'd1);
        chk("flush_taken",  {31'd0, flush},  32'd1);
        chk("branch_target", branch_target, 32'h40);
        in_zf = 1'b0;
        #1;
        chk("pc_src_nz", {31'd0, pc_src}, 32'd0);
        chk("flush_nz",  {31'd0, flush},  32'd0);
        in_zf = 1'b1; in_branch = 1'b0;
        #1;
        chk("pc_src_nobr", {31'd0, pc_src}, 32'd0);
        nop();

        //  rd   wr   addr          wdata         rw   wreg  exp_rdata     rw   mis  lc sc
        op(1'b0, 1'b1, 32'h10,      32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 0, 1);
        op(1'b1, 1'b0, 32'h10,      32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1, 1);
        op(1'b0, 1'b1, 32'h0,       32'h11111111, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1, 2);
        op(1'b0, 1'b1, 32'h100,     32'h22222222, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1, 3);
        op(1'b1, 1'b0, 32'h0,       32'h0,        1'b1, 5'd7, 32'h22222222, 1'b1, 1'b0, 2, 3);
        op(1'b0, 1'b1, 32'h8,       32'hA,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 2, 4);
        op(1'b1, 1'b1, 32'h8,       32'hB,        1'b1, 5'd3, 32'hA,        1'b1, 1'b0, 3, 5);
        op(1'b1, 1'b0, 32'h8,       32'h0,        1'b1, 5'd3, 32'hB,        1'b1, 1'b0, 4, 5);
        op(1'b1, 1'b0, 32'h13,      32'h0,        1'b1, 5'd9, 32'h0,        1'b0, 1'b1, 4, 5);
        op(1'b0, 1'b1, 32'h12,      32'h99,       1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 4, 5);
        op(1'b1, 1'b0, 32'h10,      32'h0,        1'b1, 5'd4, 32'hDEADBEEF, 1'b1, 1'b1, 5, 5);
        op(1'b0, 1'b0, 32'h10,      32'h0,        1'b1, 5'd2, 32'h0,        1'b1, 1'b1, 5, 5);
        drain();

        // Asynchronous reset between edges, then a store attempted under reset.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        in_mem_write = 1'b1; in_alu_result = 32'h10; in_store_data = 32'h55;
        @(negedge clk);
        chk_zero("rst_held");
        nop();
        rst = 1'b0;

        op(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 5'd1, 32'hDEADBEEF, 1'b1, 1'b0, 1, 0);
        op(1'b1, 1'b0, 32'h8,  32'h0, 1'b1, 5'd1, 32'hB,        1'b1, 1'b0, 2, 0);
        // Counter saturates at 7 with CNT_W=3.
        for (int i = 3; i <= 9; i++) begin
            op(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 5'd0, 32'hB, 1'b0, 1'b0, (i > 7) ? 7 : i, 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
